// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the capture/dump RAM port arbiter.
package ram_port_arbiter_pkg;

    localparam int unsigned CH_SEL_W = 3;

    // Channel select value that addresses no channel
    localparam logic [CH_SEL_W-1:0] CH_NONE = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAP  = 2'd1,
        DUMP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line carrying a valid bit and a channel tag alongside the RAM read latency.
module rd_tag_pipe #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned TAG_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);

    logic [RD_LAT-1:0] vld_q;
    logic [TAG_W-1:0]  tag_q [RD_LAT];

    // Shift valid/tag one stage per clock; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            tag_q[0] <= in_tag;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_tag   = tag_q[RD_LAT-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates one RAM port between the capture SM (absolute priority) and the dump SM,
// and returns dump read data from the channel selected at issue time.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cap_req,
    input  logic                     cap_we,
    input  logic [ADDR_W-1:0]        cap_addr,
    input  logic                     dump_req,
    input  logic [ADDR_W-1:0]        dump_addr,
    input  logic [CH_SEL_W-1:0]      ch_sel,
    input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
    output logic                     en,
    output logic                     we,
    output logic [ADDR_W-1:0]        addr,
    output logic                     cap_gnt,
    output logic                     dump_gnt,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        read_data,
    output logic                     preempt
);

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic                en_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                preempt_d;
    logic [CH_SEL_W-1:0] ch_sel_q;
    logic                pipe_valid;
    logic [CH_SEL_W-1:0] pipe_tag;
    logic [DATA_W-1:0]   sel_data;

    // Next owner of the port: capture always wins, dump only when capture is idle
    always_comb begin
        state_d   = IDLE;
        en_d      = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr;
        preempt_d = preempt;
        if (cap_req) begin
            state_d   = CAP;
            en_d      = 1'b1;
            we_d      = cap_we;
            addr_d    = cap_addr;
            preempt_d = preempt | dump_req;
        end else if (dump_req) begin
            state_d = DUMP;
            en_d    = 1'b1;
            addr_d  = dump_addr;
        end
    end

    // State and registered RAM-port outputs; ch_sel is captured with the grant it tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            en       <= 1'b0;
            we       <= 1'b0;
            addr     <= '0;
            cap_gnt  <= 1'b0;
            dump_gnt <= 1'b0;
            preempt  <= 1'b0;
            ch_sel_q <= CH_NONE;
        end else begin
            state_q  <= state_d;
            en       <= en_d;
            we       <= we_d;
            addr     <= addr_d;
            cap_gnt  <= (state_d == CAP);
            dump_gnt <= (state_d == DUMP);
            preempt  <= preempt_d;
            ch_sel_q <= ch_sel;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT),
        .TAG_W  (CH_SEL_W)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (state_q == DUMP),
        .in_tag    (ch_sel_q),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag)
    );

    // Pick the tagged channel slice; an out-of-range tag yields zero
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pipe_tag == CH_SEL_W'(i + 1)) begin
                sel_data = ch_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register completed reads; read_data holds between completions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            read_data <= '0;
        end else begin
            rd_valid <= pipe_valid;
            if (pipe_valid) begin
                read_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: two arbiters (RD_LAT=1 and RD_LAT=3) share stimulus, each with a RAM model.
module tb_ram_port_arbiter;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        cap_req;
    logic        cap_we;
    logic [8:0]  cap_addr;
    logic        dump_req;
    logic [8:0]  dump_addr;
    logic [2:0]  ch_sel;

    logic [23:0] rdata1, rdata3;
    logic        en1, we1, cg1, dg1, rv1, pe1;
    logic        en3, we3, cg3, dg3, rv3, pe3;
    logic [8:0]  addr1, addr3;
    logic [7:0]  rd1, rd3;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t q1[$];
    exp_t q3[$];
    logic [7:0] last1 = 8'h00;
    logic [7:0] last3 = 8'h00;

    logic [8:0] a1_q;
    logic [8:0] a3_q [3];

    ram_port_arbiter #(.NUM_CH(3), .DATA_W(8), .ADDR_W(9), .RD_LAT(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .cap_req(cap_req), .cap_we(cap_we), .cap_addr(cap_addr),
        .dump_req(dump_req), .dump_addr(dump_addr), .ch_sel(ch_sel), .ch_rdata(rdata1),
        .en(en1), .we(we1), .addr(addr1), .cap_gnt(cg1), .dump_gnt(dg1),
        .rd_valid(rv1), .read_data(rd1), .preempt(pe1)
    );

    ram_port_arbiter #(.NUM_CH(3), .DATA_W(8), .ADDR_W(9), .RD_LAT(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .cap_req(cap_req), .cap_we(cap_we), .cap_addr(cap_addr),
        .dump_req(dump_req), .dump_addr(dump_addr), .ch_sel(ch_sel), .ch_rdata(rdata3),
        .en(en3), .we(we3), .addr(addr3), .cap_gnt(cg3), .dump_gnt(dg3),
        .rd_valid(rv3), .read_data(rd3), .preempt(pe3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM content: pure function of channel and address
    function automatic logic [7:0] ram_byte(input int ch, input logic [8:0] a);
        return 8'(int'(a) * 3 + ch * 71);
    endfunction

    function automatic logic [7:0] exp_byte(input logic [2:0] s, input logic [8:0] a);
        if (s >= 3'd1 && s <= 3'd3) return ram_byte(int'(s), a);
        return 8'h00;
    endfunction

    // RAM models with 1 and 3 cycle read latency
    always @(posedge clk) begin
        a1_q    <= addr1;
        a3_q[0] <= addr3;
        a3_q[1] <= a3_q[0];
        a3_q[2] <= a3_q[1];
    end

    always_comb begin
        rdata1 = {ram_byte(3, a1_q), ram_byte(2, a1_q), ram_byte(1, a1_q)};
        rdata3 = {ram_byte(3, a3_q[2]), ram_byte(2, a3_q[2]), ram_byte(1, a3_q[2])};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop/compare for one instance
    task automatic mon(input int k, input logic rdv, input logic [7:0] rd);
        exp_t  e;
        bit    have;
        string p;
        p    = (k == 0) ? "L1" : "L3";
        have = 1'b0;
        if (k == 0) begin
            if (q1.size() > 0 && (rdv || q1[0].cyc <= cyc)) begin
                e = q1.pop_front(); have = 1'b1;
            end
        end else begin
            if (q3.size() > 0 && (rdv || q3[0].cyc <= cyc)) begin
                e = q3.pop_front(); have = 1'b1;
            end
        end
        if (rdv) begin
            if (!have) begin
                check({p, "_unexpected_rd_valid"}, 32'd1, 32'd0);
            end else begin
                check({p, "_read_data"}, 32'(rd), 32'(e.data));
                check({p, "_rd_valid_cycle"}, 32'(cyc), 32'(e.cyc));
            end
            if (k == 0) last1 = rd; else last3 = rd;
        end else begin
            if (have) check({p, "_rd_valid_missing"}, 32'd0, 32'd1);
            check({p, "_read_data_hold"}, 32'(rd), 32'((k == 0) ? last1 : last3));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, rv1, rd1);
            mon(1, rv3, rd3);
        end
    end

    // Drive one cycle of requests at a negedge; log expected dump reads
    task automatic drive(input logic c, input logic cw, input logic [8:0] ca,
                         input logic d, input logic [8:0] da, input logic [2:0] s);
        exp_t e;
        cap_req   = c;
        cap_we    = cw;
        cap_addr  = ca;
        dump_req  = d;
        dump_addr = da;
        ch_sel    = s;
        if (d && !c) begin
            e.data = exp_byte(s, da);
            e.cyc  = cyc + 3;
            q1.push_back(e);
            e.cyc  = cyc + 5;
            q3.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 3'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cap_req   = 1'b1;
        cap_we    = 1'b0;
        cap_addr  = 9'h0AB;
        dump_req  = 1'b0;
        dump_addr = 9'h000;
        ch_sel    = 3'd0;
        repeat (3) @(negedge clk);

        // Reset state with capture request held
        check("rst_en",        32'(en1), 32'd0);
        check("rst_we",        32'(we1), 32'd0);
        check("rst_addr",      32'(addr1), 32'd0);
        check("rst_cap_gnt",   32'(cg1), 32'd0);
        check("rst_dump_gnt",  32'(dg1), 32'd0);
        check("rst_rd_valid",  32'(rv1), 32'd0);
        check("rst_read_data", 32'(rd1), 32'd0);
        check("rst_preempt",   32'(pe1), 32'd0);
        check("rst_l3_en",     32'(en3), 32'd0);
        check("rst_l3_rd_valid", 32'(rv3), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("first_en",       32'(en1), 32'd1);
        check("first_cap_gnt",  32'(cg1), 32'd1);
        check("first_addr",     32'(addr1), 32'h0AB);
        check("first_we",       32'(we1), 32'd0);
        check("first_dump_gnt", 32'(dg1), 32'd0);

        // Dump burst 0x010..0x013 from channel 2
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 9'h000, 1'b1, 9'(9'h010 + i), 3'd2);
        check("dump_gnt_in_burst", 32'(dg1), 32'd1);
        check("dump_addr_in_burst", 32'(addr1), 32'h013);
        idle(1);
        check("idle_en",   32'(en1), 32'd0);
        check("idle_addr_hold", 32'(addr1), 32'h013);
        idle(7);
        check("preempt_still_clear", 32'(pe1), 32'd0);

        // Capture write preempts a dump burst on its third cycle
        drive(1'b0, 1'b0, 9'h000, 1'b1, 9'h020, 3'd2);
        drive(1'b0, 1'b0, 9'h000, 1'b1, 9'h021, 3'd2);
        drive(1'b1, 1'b1, 9'h1FF, 1'b1, 9'h022, 3'd2);
        check("preempt_en",       32'(en1), 32'd1);
        check("preempt_we",       32'(we1), 32'd1);
        check("preempt_addr",     32'(addr1), 32'h1FF);
        check("preempt_dump_gnt", 32'(dg1), 32'd0);
        check("preempt_cap_gnt",  32'(cg1), 32'd1);
        check("preempt_flag",     32'(pe1), 32'd1);
        check("preempt_flag_l3",  32'(pe3), 32'd1);
        drive(1'b0, 1'b0, 9'h000, 1'b1, 9'h023, 3'd1);
        idle(8);
        check("preempt_sticky", 32'(pe1), 32'd1);

        // Channel select changes between back-to-back grants
        drive(1'b0, 1'b0, 9'h000, 1'b1, 9'h030, 3'd1);
        drive(1'b0, 1'b0, 9'h000, 1'b1, 9'h031, 3'd3);
        idle(8);

        // Invalid channel selects return zero
        drive(1'b0, 1'b0, 9'h000, 1'b1, 9'h040, 3'd0);
        drive(1'b0, 1'b0, 9'h000, 1'b1, 9'h041, 3'd5);
        drive(1'b0, 1'b0, 9'h000, 1'b1, 9'h042, 3'd7);
        idle(8);

        // Random mix of capture and dump traffic
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 9'($urandom),
                  1'($urandom_range(0, 3) != 0), 9'($urandom), 3'($urandom_range(0, 7)));
        end
        idle(8);

        // Reset with two reads in flight discards them
        drive(1'b0, 1'b0, 9'h000, 1'b1, 9'h050, 3'd1);
        drive(1'b0, 1'b0, 9'h000, 1'b1, 9'h051, 3'd2);
        rst_n    = 1'b0;
        cap_req  = 1'b0;
        dump_req = 1'b0;
        q1.delete();
        q3.delete();
        last1 = 8'h00;
        last3 = 8'h00;
        repeat (2) @(negedge clk);
        check("mid_rst_preempt", 32'(pe1), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            check("post_rst_rv_l1", 32'(rv1), 32'd0);
            check("post_rst_rv_l3", 32'(rv3), 32'd0);
        end
        drive(1'b0, 1'b0, 9'h000, 1'b1, 9'h060, 3'd3);
        idle(8);

        check("l1_queue_drained", 32'(q1.size()), 32'd0);
        check("l3_queue_drained", 32'(q3.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter NUM_CH, default 3, number of capture RAM channels (1..7).
REQ-002 Parameter DATA_W, default 8, sample width per channel.
REQ-003 Parameter ADDR_W, default 9, RAM address width.
REQ-004 Parameter RD_LAT, default 1, RAM read latency in clk cycles (1..4).
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 cap_req  input  1  capture SM requests a RAM access.
REQ-008 cap_we  input  1  capture access is a write when high.
REQ-009 cap_addr  input  ADDR_W  capture address.
REQ-010 dump_req  input  1  dump SM requests a RAM read.
REQ-011 dump_addr  input  ADDR_W  dump address.
REQ-012 ch_sel  input  3  read channel select; 1..NUM_CH valid, 0 or >NUM_CH selects none.
REQ-013 ch_rdata  input  NUM_CH*DATA_W  packed RAM read data, channel 1 in LSBs.
REQ-014 en  output  1  RAM enable.
REQ-015 we  output  1  RAM write enable; high only with en.
REQ-016 addr  output  ADDR_W  RAM address.
REQ-017 cap_gnt  output  1  capture access issued this cycle.
REQ-018 dump_gnt  output  1  dump read issued this cycle.
REQ-019 rd_valid  output  1  read_data holds a completed dump read.
REQ-020 read_data  output  DATA_W  selected channel read data.
REQ-021 preempt  output  1  sticky; set when capture displaces a pending dump request.

Function
REQ-022 en, we, addr, cap_gnt and dump_gnt shall be registered: requests sampled at edge t drive outputs during cycle t+1.
REQ-023 The FSM shall have states IDLE, CAP and DUMP; the state register selects the owner of the RAM port during the current cycle.
REQ-024 Any state with cap_req=1 -> CAP next cycle: en=1, we=cap_we, addr=cap_addr, cap_gnt=1.
REQ-025 cap_req=0 and dump_req=1 -> DUMP next cycle: en=1, we=0, addr=dump_addr, dump_gnt=1.
REQ-026 Neither request -> IDLE: en=0, we=0, gnt=0, addr holds last value.
REQ-027 Capture has absolute priority and shall preempt an ongoing dump burst without a wait cycle.
REQ-028 cap_req and dump_req sampled high together shall set preempt; preempt clears only on reset.
REQ-029 Each DUMP cycle shall push the registered ch_sel into a tag pipeline of depth RD_LAT.
REQ-030 rd_valid shall assert exactly RD_LAT+1 cycles after the dump_gnt cycle, one per grant, in issue order.
REQ-031 read_data shall register the ch_rdata slice chosen by the tag, not the live ch_sel; ch_sel changes mid-burst shall not corrupt in-flight reads.
REQ-032 An invalid tag shall give read_data=0 with rd_valid still asserted.
REQ-033 read_data shall hold its value while rd_valid=0.
REQ-034 Reads in flight when capture preempts shall still complete with rd_valid.

Reset
REQ-035 rst_n low shall asynchronously force state=IDLE, en=0, we=0, addr=0, cap_gnt=0, dump_gnt=0, rd_valid=0, read_data=0, preempt=0, and clear the tag pipeline.
REQ-036 Reads in flight at reset shall be discarded; no rd_valid after reset release without a new grant.

Structure
REQ-037 A shared package shall hold the FSM state enum (IDLE, CAP, DUMP) and the "no channel" select encoding 0.
REQ-038 The tag/valid delay line shall be a sub-module rd_tag_pipe parametrised by RD_LAT and tag width.

Verification
REQ-039 Reset with cap_req=1 held -> all outputs 0; first edge after release -> en=1, cap_gnt=1, addr=cap_addr.
REQ-040 dump_req=1 addr 0x010..0x013, ch_sel=2, RD_LAT=1 -> rd_valid on cycles 2..5 after first grant, read_data=ch2 data per address.
REQ-041 Dump burst, cap_req=1 at third cycle (cap_we=1, addr 0x1FF) -> next cycle en=1, we=1, addr=0x1FF, dump_gnt=0, preempt=1; earlier reads still return rd_valid.
REQ-042 ch_sel 1->3 between back-to-back dump grants, RD_LAT=3 -> data from ch1 then ch3, in order.
REQ-043 ch_sel=0, then ch_sel=5 with NUM_CH=3 -> rd_valid=1, read_data=0x00.
REQ-044 rst_n pulsed low with two reads in flight -> rd_valid stays 0 until a new dump grant.
